spi_xfer_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one byte-level SPI master engine between NUM_REQ requesters. It grants the bus to one requester and drives that requester's active-low slave select. It then issues LEN+1 back-to-back byte transfers through the engine's start/tx_ready/done handshake and returns each received byte to the owner. It sits between client blocks (counters, sensor pollers) and the SPI master.

---
 rtl/spi_xfer_arbiter.sv | 149 ++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one byte-level SPI master among NUM_REQ clients.
// Each grant frames LEN+1 back-to-back bytes with slave-select setup and hold time.
module spi_xfer_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int LEN_W     = 4,
    parameter int SETUP_CYC = 4,
    parameter int HOLD_CYC  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     req_tx_data,
    output logic [NUM_REQ-1:0]       tx_pop,
    output logic [7:0]               rx_data,
    output logic [NUM_REQ-1:0]       rx_valid,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       xfer_done,
    output logic [NUM_REQ-1:0]       ss_n,
    output logic                     spi_start,
    output logic [7:0]               spi_tx_data,
    input  logic                     spi_tx_ready,
    input  logic                     spi_done,
    input  logic [7:0]               spi_rx_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;

    state_t             state_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [NUM_REQ-1:0] ss_n_reg;
    logic [NUM_REQ-1:0] xfer_done_reg;
    logic [IDX_W-1:0]   last_grant_reg;
    logic [IDX_W-1:0]   owner_reg;
    logic [LEN_W-1:0]   byte_cnt_reg;
    logic [7:0]         cyc_cnt_reg;

    logic [LEN_W-1:0]   len_arr   [NUM_REQ];
    logic [7:0]         tx_masked [NUM_REQ];
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   winner;
    logic               found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign len_arr[gi]    = req_len[gi*LEN_W +: LEN_W];
            assign tx_masked[gi]  = grant_reg[gi] ? req_tx_data[gi*8 +: 8] : 8'h00;
            assign win_onehot[gi] = found && (winner == IDX_W'(gi));
        end
    endgenerate

    // Search begins just after the last owner so the previous winner ranks last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!found && req[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        spi_tx_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++)
            spi_tx_data = spi_tx_data | tx_masked[i];
    end

    assign spi_start = (state_reg == START) && spi_tx_ready;
    assign tx_pop    = spi_start ? grant_reg : '0;
    assign rx_valid  = ((state_reg == WAIT) && spi_done) ? grant_reg : '0;
    assign rx_data   = spi_rx_data;
    assign grant     = grant_reg;
    assign ss_n      = ss_n_reg;
    assign xfer_done = xfer_done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            ss_n_reg       <= '1;
            xfer_done_reg  <= '0;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            owner_reg      <= '0;
            byte_cnt_reg   <= '0;
            cyc_cnt_reg    <= '0;
        end else begin
            xfer_done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        grant_reg    <= win_onehot;
                        ss_n_reg     <= ~win_onehot;
                        owner_reg    <= winner;
                        byte_cnt_reg <= len_arr[winner];
                        cyc_cnt_reg  <= '0;
                        state_reg    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cyc_cnt_reg == 8'(SETUP_CYC - 1)) begin
                        cyc_cnt_reg <= '0;
                        state_reg   <= START;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 8'd1;
                    end
                end
                START: begin
                    if (spi_tx_ready)
                        state_reg <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        if (byte_cnt_reg == '0) begin
                            cyc_cnt_reg <= '0;
                            state_reg   <= HOLD;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg - 1'b1;
                            state_reg    <= START;
                        end
                    end
                end
                HOLD: begin
                    // xfer_done rises on the same edge that releases the slave select.
                    if (cyc_cnt_reg == 8'(HOLD_CYC - 1)) begin
                        ss_n_reg       <= '1;
                        grant_reg      <= '0;
                        last_grant_reg <= owner_reg;
                        xfer_done_reg  <= grant_reg;
                        state_reg      <= IDLE;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a loopback SPI engine model and a
// per-transaction table of expected owner, byte counts and framing.
module tb_spi_xfer_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int LEN_W     = 4;
    localparam int SETUP_CYC = 4;
    localparam int HOLD_CYC  = 4;
    localparam int ENG_LAT   = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ*8-1:0]     req_tx_data;
    logic [NUM_REQ-1:0]       tx_pop;
    logic [7:0]               rx_data;
    logic [NUM_REQ-1:0]       rx_valid;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       xfer_done;
    logic [NUM_REQ-1:0]       ss_n;
    logic                     spi_start;
    logic [7:0]               spi_tx_data;
    logic                     spi_tx_ready;
    logic                     spi_done;
    logic [7:0]               spi_rx_data;

    spi_xfer_arbiter #(
        .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_tx_data(req_tx_data),
        .tx_pop(tx_pop), .rx_data(rx_data), .rx_valid(rx_valid), .grant(grant),
        .xfer_done(xfer_done), .ss_n(ss_n), .spi_start(spi_start), .spi_tx_data(spi_tx_data),
        .spi_tx_ready(spi_tx_ready), .spi_done(spi_done), .spi_rx_data(spi_rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [3:0] len0;
        logic [3:0] len1;
        bit         keep;
        bit         drop;
        int         stall;
        int         exp_owner;
        int         exp_bytes;
    } row_t;

    row_t rows [10];

    int checks = 0;
    int errors = 0;

    int         eng_cnt;
    logic [7:0] eng_byte;
    int         ptr [NUM_REQ];
    int         cur_row;
    logic [1:0] req_drive;
    bit         keep, drop;
    int         stall, exp_bytes;
    int         n_start, n_pop, n_rx, data_bad, pre_cnt, hold_cnt, done_cnt, viol, ss_idx, owner;
    logic [1:0] done_vec;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] tx_byte(input int r, input int k);
        if (r == 0) begin
            case (k)
                0: return 8'hA5;
                1: return 8'h3C;
                default: return 8'hF0;
            endcase
        end
        return 8'(r*16 + k*7) ^ 8'h5A;
    endfunction

    task automatic clear_stats();
        n_start = 0; n_pop = 0; n_rx = 0; data_bad = 0; pre_cnt = 0; hold_cnt = 0;
        done_cnt = 0; viol = 0; ss_idx = 0; owner = -1; done_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) ptr[i] = 0;
    endtask

    // One clock: drive engine/client inputs after the falling edge, sample 1ns later.
    task automatic tick();
        @(negedge clk);
        spi_done     = (eng_cnt == 1);
        spi_rx_data  = (eng_cnt == 1) ? eng_byte : 8'hEE;
        spi_tx_ready = (eng_cnt == 0) &&
                       !(stall > 0 && ss_n != '1 && ss_idx < SETUP_CYC + stall);
        for (int i = 0; i < NUM_REQ; i++)
            req_tx_data[i*8 +: 8] = tx_byte(cur_row, ptr[i]);
        req = req_drive;
        #1;
        if (ss_n != '1) begin
            if (owner < 0)
                for (int i = 0; i < NUM_REQ; i++)
                    if (grant[i]) owner = i;
            if (n_start == 0 && !spi_start) pre_cnt++;
            if (n_rx > 0) hold_cnt++;
            ss_idx++;
        end
        if ($countones(~ss_n) > 1) viol++;
        if (ss_n != ~grant) viol++;
        if (tx_pop != (spi_start ? grant : 2'b00)) viol++;
        if (spi_start) begin
            if (spi_tx_data != tx_byte(cur_row, n_start)) data_bad++;
            n_start++;
            eng_byte = spi_tx_data;
            eng_cnt  = ENG_LAT;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
        end
        for (int i = 0; i < NUM_REQ; i++)
            if (tx_pop[i]) begin
                n_pop++;
                ptr[i]++;
            end
        if (rx_valid != '0) begin
            if (rx_valid != grant) viol++;
            if (rx_data != tx_byte(cur_row, n_rx)) data_bad++;
            n_rx++;
            hold_cnt = 0;
            if (drop || (!keep && n_rx == exp_bytes)) req_drive = '0;
        end
        if (xfer_done != '0) begin
            done_cnt++;
            done_vec = xfer_done;
            if (ss_n != '1 || grant != '0) viol++;
        end
    endtask

    task automatic run_row(input int r);
        cur_row   = r;
        req_drive = rows[r].req;
        req_len   = {rows[r].len1, rows[r].len0};
        keep      = rows[r].keep;
        drop      = rows[r].drop;
        stall     = rows[r].stall;
        exp_bytes = rows[r].exp_bytes;
        clear_stats();
        for (int t = 0; t < 3000 && done_cnt == 0; t++) tick();
        check("owner",          owner,    rows[r].exp_owner);
        check("spi_start_cnt",  n_start,  exp_bytes);
        check("tx_pop_cnt",     n_pop,    exp_bytes);
        check("rx_valid_cnt",   n_rx,     exp_bytes);
        check("data_errors",    data_bad, 0);
        check("setup_cycles",   pre_cnt,  SETUP_CYC + stall);
        check("hold_cycles",    hold_cnt, HOLD_CYC);
        check("xfer_done_cnt",  done_cnt, 1);
        check("xfer_done_vec",  int'(done_vec), 1 << rows[r].exp_owner);
        check("protocol_viol",  viol,     0);
        $display("txn row %0d: owner %0d, starts %0d, rx %0d, setup %0d, hold %0d",
                 r, owner, n_start, n_rx, pre_cnt, hold_cnt);
    endtask

    initial begin
        //           req    len0  len1  keep drop stall owner bytes
        rows[0] = '{2'b01, 4'd2,  4'd0, 1'b0, 1'b0, 0,  0, 3};
        rows[1] = '{2'b11, 4'd0,  4'd0, 1'b1, 1'b0, 0,  1, 1};
        rows[2] = '{2'b11, 4'd0,  4'd0, 1'b1, 1'b0, 0,  0, 1};
        rows[3] = '{2'b11, 4'd0,  4'd0, 1'b1, 1'b0, 0,  1, 1};
        rows[4] = '{2'b11, 4'd0,  4'd0, 1'b0, 1'b0, 0,  0, 1};
        rows[5] = '{2'b10, 4'd0,  4'd1, 1'b0, 1'b0, 20, 1, 2};
        rows[6] = '{2'b10, 4'd0,  4'd3, 1'b0, 1'b1, 0,  1, 4};
        rows[7] = '{2'b01, 4'd15, 4'd0, 1'b0, 1'b0, 0,  0, 16};
        rows[8] = '{2'b11, 4'd1,  4'd2, 1'b0, 1'b0, 0,  1, 3};
        rows[9] = '{2'b10, 4'd0,  4'd2, 1'b0, 1'b0, 0,  1, 3};

        reset = 1'b0; req = '0; req_len = '0; req_tx_data = '0;
        spi_tx_ready = 1'b0; spi_done = 1'b0; spi_rx_data = '0;
        eng_cnt = 0; eng_byte = '0; req_drive = '0; cur_row = 0;
        keep = 0; drop = 0; stall = 0; exp_bytes = 0;
        clear_stats();

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_ss_n",        int'(ss_n),        3);
        check("reset_grant",       int'(grant),       0);
        check("reset_spi_start",   int'(spi_start),   0);
        check("reset_tx_pop",      int'(tx_pop),      0);
        check("reset_xfer_done",   int'(xfer_done),   0);
        check("reset_spi_tx_data", int'(spi_tx_data), 0);
        reset = 1'b1;

        for (int r = 0; r < 9; r++) run_row(r);

        // spi_done while idle must not produce rx_valid or a grant.
        clear_stats();
        req_drive = '0;
        eng_cnt   = 1;
        tick();
        check("idle_done_ignored", n_rx, 0);
        check("idle_no_grant", int'(grant), 0);

        // Reset while waiting on the second byte aborts without xfer_done.
        cur_row = 20; req_drive = 2'b01; req_len = {4'd0, 4'd3};
        keep = 0; drop = 0; stall = 0; exp_bytes = 4;
        clear_stats();
        for (int t = 0; t < 300 && n_start < 2; t++) tick();
        tick();
        check("abort_reached_byte2", n_start, 2);
        req_drive = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ss_n_async",  int'(ss_n),  3);
        check("abort_grant_async", int'(grant), 0);
        eng_cnt = 0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("abort_no_xfer_done", done_cnt, 0);
        check("abort_viol", viol, 0);
        $display("txn abort: starts %0d, xfer_done %0d", n_start, done_cnt);

        run_row(9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
